// File: rtl/mac_vector_feeder.sv
// Packs serial pixel/weight byte pairs into 16-lane MAC vectors, tags each vector and
// accumulates NUM_CHUNKS returned chunk sums per neuron. Build option: MAC_FEED_SAT_EN.
module mac_vector_feeder #(
    parameter int NUM_CHUNKS = 49,
    parameter int ACC_W      = 26,
    parameter int SHIFT      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_pixel,
    input  logic [7:0]       in_weight,
    output logic [127:0]     pixels,
    output logic [127:0]     weights,
    output logic             vec_strobe,
    input  logic [19:0]      sumout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);
    localparam int LANES   = 16;
    localparam int MAC_LAT = 3;
    localparam int RC_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
`ifdef MAC_FEED_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [3:0]             bidx;
    logic [LANES-1:0][7:0]  stg_pix, stg_wt;
    logic [MAC_LAT:1]       vld_pipe;
    logic [RC_W-1:0]        rc;
    logic [ACC_W-1:0]       acc, acc_nxt, result, shifted;
    logic                   accept, last_byte, last_chunk, sum_here;

    assign in_ready   = !rst && (!res_valid || res_ready);
    assign accept     = in_valid && in_ready;
    assign last_byte  = (bidx == 4'd15);
    assign sum_here   = vld_pipe[MAC_LAT];
    assign last_chunk = (rc == RC_W'(NUM_CHUNKS - 1));
    assign acc_nxt    = (rc == '0) ? ACC_W'(sumout) : acc + ACC_W'(sumout);

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx    <= '0;
            stg_pix <= '0;
            stg_wt  <= '0;
        end else if (accept) begin
            bidx <= bidx + 4'd1;
            // lane k lives at element 15-k, so byte 0 ends up in the MSBs (MAC lane 0)
            stg_pix[~bidx] <= in_pixel;
            stg_wt[~bidx]  <= in_weight;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixels     <= '0;
            weights    <= '0;
            vec_strobe <= 1'b0;
        end else begin
            vec_strobe <= accept && last_byte;
            if (accept && last_byte) begin
                pixels  <= {stg_pix[LANES-1:1], in_pixel};
                weights <= {stg_wt[LANES-1:1], in_weight};
            end
        end
    end

    // Tag tracks each vector through the MAC; the top bit lines up with its sumout.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[MAC_LAT-1:1], vec_strobe};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            rc  <= '0;
        end else if (sum_here) begin
            acc <= acc_nxt;
            rc  <= last_chunk ? '0 : rc + RC_W'(1);
        end
    end

    // Result register is separate so the next neuron can accumulate while this one waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            res_valid <= 1'b0;
        end else if (sum_here && last_chunk) begin
            result    <= acc_nxt;
            res_valid <= 1'b1;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign shifted  = result >> SHIFT;
    assign res_data = !SAT_EN ? result
                    : (shifted > ACC_W'(255)) ? ACC_W'(255) : shifted;
endmodule

// File: doc/mac_vector_feeder.md
# mac_vector_feeder

Streaming front end for the 16-lane multiply/adder-tree MAC pipeline. It packs serial 8-bit pixel/weight byte pairs into the 128-bit `pixels`/`weights` vectors the MAC consumes, and tags each issued vector. It collects the 20-bit `sumout` returned three cycles later and accumulates `NUM_CHUNKS` chunk sums into one neuron pre-activation. The completed result is presented on a valid/ready port to the activation/next-layer logic.

## Interface
- `NUM_CHUNKS`, 49, 16-byte chunks per neuron (784 inputs = 28x28 image).
- `ACC_W`, 26, accumulator/result width. Must satisfy `ACC_W >= 20 + ceil(log2(NUM_CHUNKS))`.
- `SHIFT`, 10, right shift applied before saturation. Used only with `MAC_FEED_SAT_EN`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: byte pair valid.
- `in_ready` out 1: feeder accepts the byte pair this cycle.
- `in_pixel` in 8: unsigned pixel byte.
- `in_weight` in 8: unsigned weight byte.
- `pixels` out 128: packed pixel vector to the MAC.
- `weights` out 128: packed weight vector to the MAC.
- `vec_strobe` out 1: `pixels`/`weights` carry a new vector this cycle.
- `sumout` in 20: chunk sum from the MAC.
- `res_valid` out 1: neuron result valid.
- `res_ready` in 1: consumer takes the result.
- `res_data` out ACC_W: neuron result.

## Operation
- Transfer: a byte pair is accepted when `in_valid && in_ready`.
- `in_ready` = `!res_valid || res_ready`. The input stalls only while a result is pending and not being taken.
- Byte counter `bidx` runs 0..15. Accepted byte k goes to staging bits [127-8k : 120-8k], so byte 0 lands in the MSB lane, matching MAC lane 0.
- On acceptance with `bidx==15`:
  - staging, including the current byte, loads into the `pixels`/`weights` output registers;
  - `vec_strobe` goes high for exactly the next cycle;
  - `bidx` wraps to 0.
- Output registers hold their value between strobes.
- A 3-deep tag shift register is fed by `vec_strobe`. Tag bit 2 marks the cycle in which `sumout` holds that vector's sum.
- When the tag is set:
  - the accumulator loads `sumout` zero-extended if the result-chunk counter `rc` is 0, otherwise adds it;
  - `rc` increments.
- When `rc == NUM_CHUNKS-1` and the tag is set:
  - the final sum `acc+sumout` is written to the result register;
  - `res_valid` is set;
  - `rc` returns to 0.
- `res_valid` clears on `res_valid && res_ready`.
- Chunks of the next neuron may issue and accumulate while a result is pending. The result register is separate from the accumulator.
- Arithmetic is unsigned throughout. With `ACC_W` sized per its rule there is no overflow: the worst case for 49 chunks is 49 x 1,040,400 = 50,979,600 < 2^26.

## Timing
- Strobe cycle is T, meaning `vec_strobe=1` and the vector is on the outputs.
- The MAC registers the inputs at the end of T, the products at T+1 and `sumout` at T+2. `sumout` is valid during T+3 and is added at the end of T+3.
- Byte-to-strobe latency: the 16th byte is accepted in cycle A and the strobe is at A+1.
- Last chunk: `res_valid` rises at A+5 after the last byte is accepted in cycle A.
- Minimum strobe spacing is 16 cycles, so tag entries never collide.
- Reset values:
  - `pixels`=0, `weights`=0, `vec_strobe`=0;
  - `res_valid`=0, `res_data`=0;
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after.
- Reset mid-operation:
  - clears `bidx`, `rc`, staging, tags and the accumulator;
  - drops any pending result;
  - sums still inside the MAC when reset deasserts are ignored, because their tags were cleared.
- Simultaneous events:
  - result taken and new final sum in the same cycle: the new result is written and `res_valid` stays 1;
  - tag set and `rst` in the same cycle: reset wins.

## Configuration
- `MAC_FEED_SAT_EN` defined:
  - `res_data` = min(`result >> SHIFT`, 255), zero-extended to `ACC_W`;
  - this is the 8-bit pixel format for the next layer.
- Not defined: `res_data` = full `ACC_W`-bit sum.
- Handshake and timing are identical in both builds.

## Test plan
The bench instantiates the MAC pipeline between `pixels`/`weights` and `sumout`.

- **Unit sum.** `NUM_CHUNKS=2`, 32 pairs of (1,1), `res_ready=1`, macro off -> one `res_valid` pulse with `res_data`=32, exactly 5 cycles after the 32nd accept.
- **Lane order.** Bytes k=0..15 with pixel=k+1, weight=1 -> at strobe `pixels`=0x0102030405060708090A0B0C0D0E0F10 and `weights`=0x01010101010101010101010101010101; `sumout` 136 three cycles later.
- **Worst case.** Default parameters, all pixels and weights 255 -> `res_data`=50,979,600. With `MAC_FEED_SAT_EN` -> `res_data`=255.
- **Backpressure.** Hold `res_ready=0` after the first result while streaming a second neuron -> `in_ready` stays 0, no bytes are accepted and the first result holds. Raising `res_ready` takes the first result, then the second neuron completes with the correct sum.
- **Reset mid-neuron.** Assert `rst` for 1 cycle after 20 pairs of (2,3) -> outputs return to reset values. A fresh unit-sum stream then yields 32 (`NUM_CHUNKS=2`) with no contribution from the pre-reset chunk.
- **Gapped input.** `in_valid` toggling every other cycle -> the same results as the contiguous stream, with strobe spacing 32 cycles.
